// File: rtl/sync_phase_ctrl.sv
// sync_phase_ctrl
//   Symbol-timing controller that sits after the RC matched filter. During a
//   search window of NSYM symbols it sums |i_rc_filter| for each of the OS
//   sample phases. It then locks to the phase with the largest sum and emits a
//   one-cycle strobe on every sample taken at that phase.
//
//   Ports
//     clock        rising-edge system clock
//     i_reset      asynchronous reset, active low
//     i_enable     block enable; 0 freezes all state and forces o_strobe low
//     i_valid      sample qualifier for i_rc_filter
//     i_rc_filter  signed filter output sample (S_IN bits)
//     i_restart    pulse: drop the lock and start a new search
//     o_phase      selected sample phase
//     o_locked     1 while locked
//     o_strobe     registered pulse one cycle after a locked-phase sample
//     o_busy       1 while searching or deciding

// One accumulator for each sample phase. A clear that coincides with a sample
// loads that sample, so a restart never drops the sample it arrives with.
module sync_phase_acc #(
    parameter int S_IN  = 10,
    parameter int ACC_W = 14
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             clr,
    input  logic             add,
    input  logic [S_IN-1:0]  mag,
    output logic [ACC_W-1:0] acc
);
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset)  acc <= '0;
        else if (clr)  acc <= add ? ACC_W'(mag) : '0;
        else if (add)  acc <= acc + ACC_W'(mag);
    end
endmodule

module sync_phase_ctrl #(
    parameter int S_IN = 10,
    parameter int OS   = 4,
    parameter int NSYM = 16
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic [S_IN-1:0]       i_rc_filter,
    input  logic                  i_restart,
    output logic [$clog2(OS)-1:0] o_phase,
    output logic                  o_locked,
    output logic                  o_strobe,
    output logic                  o_busy
);
    localparam int ACC_W = S_IN + $clog2(NSYM);
    localparam int PH_W  = $clog2(OS);
    localparam int CNT_W = $clog2(NSYM * OS);

    typedef enum logic [1:0] {SEARCH, DECIDE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph;
    logic [CNT_W-1:0]  cnt;
    logic [S_IN-1:0]   mag;
    logic [ACC_W-1:0]  acc [OS];
    logic [PH_W-1:0]   best_idx;
    logic [ACC_W-1:0]  best_val;
    logic              qual, restart, add_en, last;

    assign qual    = i_enable & i_valid;
    assign restart = i_enable & i_restart;
    // A restart sample is accumulated into the freshly cleared window.
    assign add_en  = qual & (restart | (state_q == SEARCH));

    // Two's-complement magnitude in S_IN unsigned bits; the most negative
    // input maps to 2^(S_IN-1), which still fits.
    assign mag = i_rc_filter[S_IN-1] ? (~i_rc_filter + 1'b1) : i_rc_filter;

    // The window is counted in samples from the start of the search rather
    // than from phase wraps: a restart keeps ph, so the first symbol may be
    // partial, yet every phase must still receive exactly NSYM samples.
    assign last = qual & ~restart & (state_q == SEARCH) &
                  (cnt == CNT_W'(NSYM * OS - 1));

    for (genvar g = 0; g < OS; g++) begin : g_acc
        sync_phase_acc #(.S_IN(S_IN), .ACC_W(ACC_W)) u_acc (
            .clock   (clock),
            .i_reset (i_reset),
            .clr     (restart),
            .add     (add_en & (ph == PH_W'(g))),
            .mag     (mag),
            .acc     (acc[g])
        );
    end

    // Strict '>' keeps the lowest index on a tie.
    always_comb begin
        best_idx = '0;
        best_val = acc[0];
        for (int k = 1; k < OS; k++) begin
            if (acc[k] > best_val) begin
                best_idx = PH_W'(k);
                best_val = acc[k];
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) state_q <= SEARCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH:  if (last)     state_d = DECIDE;
                DECIDE:  if (i_enable) state_d = LOCKED;
                LOCKED:                state_d = LOCKED;
                default:               state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            ph       <= '0;
            cnt      <= '0;
            o_phase  <= '0;
            o_strobe <= 1'b0;
        end else begin
            if (qual) ph <= ph + 1'b1;

            if (restart)                           cnt <= qual ? CNT_W'(1) : '0;
            else if (qual && state_q == SEARCH)    cnt <= cnt + 1'b1;

            if (i_enable && !restart && state_q == DECIDE) o_phase <= best_idx;

            o_strobe <= qual & ~i_restart & (state_q == LOCKED) & (ph == o_phase);
        end
    end

    assign o_locked = (state_q == LOCKED);
    assign o_busy   = (state_q != LOCKED);
endmodule
